muxn_rr_arb: RTL and testbench

//  Parametrised N-channel, W-bit successor to the 2:1 mux. Replaces the static select with an internal

---
 rtl/muxn_pkg.sv | 24 ++
 rtl/muxn_rr_arb_rr_grant.sv | 45 ++++
 rtl/muxn_rr_arb.sv | 102 ++++++++++
 tb/tb_muxn_rr_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared definitions for the N-channel arbitrated mux: arbitration modes and
// the width helpers used to size the channel index.
package muxn_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // An index still needs one bit when there is only a single channel.
    function automatic int sel_width(input int n_ch);
        return (n_ch <= 1) ? 1 : clog2(n_ch);
    endfunction

endpackage

// File: rtl/muxn_rr_arb_rr_grant.sv
// Combinational grant picker: rotating search from ptr (round-robin) or a
// lowest-index search (fixed priority) over the request vector.
module rr_grant
    import muxn_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  arb_mode_e        mode,
    output logic [N_CH-1:0]  gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int start;
    int idx;

    // An out-of-range pointer restarts the search at channel 0, so an index
    // >= N_CH can never be granted even when N_CH is not a power of two.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        idx        = 0;
        if (mode == ARB_FIXED || int'(ptr) >= N_CH) begin
            start = 0;
        end else begin
            start = int'(ptr);
        end
        for (int k = 0; k < N_CH; k++) begin
            idx = start + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!gnt_any && req[idx]) begin
                gnt_any         = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/muxn_rr_arb.sv
// N-channel arbitrated mux feeding a one-entry registered valid/ready output
// stage; holds the round-robin pointer and the output register.
module muxn_rr_arb
    import muxn_pkg::*;
#(
    parameter int  N_CH     = 4,
    parameter int  DATA_W   = 8,
    parameter int  ARB_MODE = 0,
    localparam int SEL_W    = sel_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam arb_mode_e MODE = (ARB_MODE != 0) ? ARB_FIXED : ARB_RR;

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;

    logic [N_CH-1:0]   gnt_onehot;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              load_en;
    logic              xfer;
    logic [DATA_W-1:0] gnt_word;

    rr_grant #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_grant (
        .req        (in_valid),
        .ptr        (ptr_q),
        .mode       (MODE),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    assign load_en = !out_valid_q || out_ready;
    assign xfer    = rst_n && load_en && gnt_any;

    // Forced low during reset so no producer sees an accept that the held
    // output register cannot honour.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en) begin
            in_ready = gnt_onehot;
        end
    end

    // One-hot select keeps the data path free of any out-of-range slice.
    always_comb begin
        gnt_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_onehot[i]) begin
                gnt_word = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        out_valid_d = xfer || (out_valid_q && !out_ready);
        out_data_d  = xfer ? gnt_word : out_data_q;
        out_sel_d   = xfer ? gnt_idx  : out_sel_q;
        ptr_d       = ptr_q;
        if (MODE == ARB_RR && xfer) begin
            if (int'(gnt_idx) == N_CH - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_muxn_rr_arb.sv
// Directed self-checking bench: round-robin (4 and 3 channels), fixed
// priority and single-channel instances driven from one clock and reset.
module tb_muxn_rr_arb;

    logic clk;
    logic rst_n;

    logic [31:0] data4;
    logic [3:0]  valid4;
    logic [3:0]  ready4;
    logic [7:0]  odata4;
    logic [1:0]  osel4;
    logic        ovalid4;
    logic        oready4;

    logic [23:0] data3;
    logic [2:0]  valid3;
    logic [2:0]  ready3;
    logic [7:0]  odata3;
    logic [1:0]  osel3;
    logic        ovalid3;
    logic        oready3;

    logic [31:0] dataF;
    logic [3:0]  validF;
    logic [3:0]  readyF;
    logic [7:0]  odataF;
    logic [1:0]  oselF;
    logic        ovalidF;
    logic        oreadyF;

    logic [7:0]  data1;
    logic [0:0]  valid1;
    logic [0:0]  ready1;
    logic [7:0]  odata1;
    logic [0:0]  osel1;
    logic        ovalid1;
    logic        oready1;

    int testsRun;
    int testsFailed;

    muxn_rr_arb #(.N_CH(4), .DATA_W(8), .ARB_MODE(0)) u4 (
        .clk(clk), .rst_n(rst_n), .in_data(data4), .in_valid(valid4), .in_ready(ready4),
        .out_data(odata4), .out_sel(osel4), .out_valid(ovalid4), .out_ready(oready4)
    );

    muxn_rr_arb #(.N_CH(3), .DATA_W(8), .ARB_MODE(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(data3), .in_valid(valid3), .in_ready(ready3),
        .out_data(odata3), .out_sel(osel3), .out_valid(ovalid3), .out_ready(oready3)
    );

    muxn_rr_arb #(.N_CH(4), .DATA_W(8), .ARB_MODE(1)) uF (
        .clk(clk), .rst_n(rst_n), .in_data(dataF), .in_valid(validF), .in_ready(readyF),
        .out_data(odataF), .out_sel(oselF), .out_valid(ovalidF), .out_ready(oreadyF)
    );

    muxn_rr_arb #(.N_CH(1), .DATA_W(8), .ARB_MODE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(data1), .in_valid(valid1), .in_ready(ready1),
        .out_data(odata1), .out_sel(osel1), .out_valid(ovalid1), .out_ready(oready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data,
                                 input logic ready);
        valid4  = valid;
        data4   = data;
        oready4 = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n   = 1'b0;
        applyStimulus(4'hF, 32'h44A52211, 1'b1);
        data3 = 24'hC2C1C0; valid3 = '0; oready3 = 1'b1;
        dataF = 32'h44332211; validF = '0; oreadyF = 1'b1;
        data1 = 8'h5A; valid1 = '0; oready1 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(ovalid4), 32'h0);
        checkOutput("reset_data", 32'(odata4), 32'h0);
        checkOutput("reset_sel", 32'(osel4), 32'h0);
        checkOutput("reset_ready", 32'(ready4), 32'h0);
        applyStimulus(4'h0, 32'h44A52211, 1'b1);
        rst_n = 1'b1;
        tick();

        // Only ch2 requesting; then ch0+ch3 to show the pointer moved to 3
        applyStimulus(4'b0100, 32'h44A52211, 1'b1);
        #1 checkOutput("single_ready", 32'(ready4), 32'b0100);
        tick();
        checkOutput("single_valid", 32'(ovalid4), 32'h1);
        checkOutput("single_data", 32'(odata4), 32'hA5);
        checkOutput("single_sel", 32'(osel4), 32'h2);
        applyStimulus(4'b1001, 32'h44A52211, 1'b1);
        #1 checkOutput("ptr3_ready", 32'(ready4), 32'b1000);
        tick();
        checkOutput("ptr3_sel", 32'(osel4), 32'h3);
        checkOutput("ptr3_data", 32'(odata4), 32'h44);

        applyStimulus(4'hF, 32'hD3D2D1D0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("rr_sel", 32'(osel4), 32'(i % 4));
            checkOutput("rr_data", 32'(odata4), 32'(8'hD0 + 8'(i % 4)));
            checkOutput("rr_valid", 32'(ovalid4), 32'h1);
        end
        applyStimulus(4'h0, 32'hD3D2D1D0, 1'b1);
        tick();
        checkOutput("drain_valid", 32'(ovalid4), 32'h0);
        checkOutput("drain_sel_hold", 32'(osel4), 32'h3);
        checkOutput("drain_data_hold", 32'(odata4), 32'hD3);

        applyStimulus(4'b0011, 32'h40302010, 1'b1);
        tick();
        checkOutput("bp_load", 32'(odata4), 32'h10);
        applyStimulus(4'b0011, 32'h40302010, 1'b0);
        repeat (5) begin
            #1 checkOutput("bp_ready", 32'(ready4), 32'h0);
            tick();
            checkOutput("bp_data", 32'(odata4), 32'h10);
            checkOutput("bp_sel", 32'(osel4), 32'h0);
            checkOutput("bp_valid", 32'(ovalid4), 32'h1);
        end
        applyStimulus(4'b0011, 32'h40302010, 1'b1);
        #1 checkOutput("bp_release_ready", 32'(ready4), 32'b0010);
        tick();
        checkOutput("bp_swap_data", 32'(odata4), 32'h20);
        checkOutput("bp_swap_sel", 32'(osel4), 32'h1);
        checkOutput("bp_swap_valid", 32'(ovalid4), 32'h1);

        // Asynchronous reset between edges while a word is held
        applyStimulus(4'hF, 32'h40302010, 1'b1);
        tick();
        checkOutput("pre_rst_data", 32'(odata4), 32'h30);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(ovalid4), 32'h0);
        checkOutput("async_data", 32'(odata4), 32'h0);
        checkOutput("async_sel", 32'(osel4), 32'h0);
        checkOutput("async_ready", 32'(ready4), 32'h0);
        tick();
        checkOutput("rst_hold_ready", 32'(ready4), 32'h0);
        rst_n = 1'b1;
        #1 checkOutput("post_rst_ready", 32'(ready4), 32'b0001);
        tick();
        checkOutput("post_rst_sel", 32'(osel4), 32'h0);
        checkOutput("post_rst_data", 32'(odata4), 32'h10);
        applyStimulus(4'h0, 32'h40302010, 1'b1);
        tick();

        // Three channels: walk the pointer to 2, then check the wrap to 0
        valid3 = 3'b010;
        tick();
        checkOutput("n3_first_sel", 32'(osel3), 32'h1);
        checkOutput("n3_first_data", 32'(odata3), 32'hC1);
        valid3 = 3'b101;
        #1 checkOutput("n3_ready_ch2", 32'(ready3), 32'b100);
        tick();
        checkOutput("n3_sel_ch2", 32'(osel3), 32'h2);
        checkOutput("n3_data_ch2", 32'(odata3), 32'hC2);
        #1 checkOutput("n3_ready_wrap", 32'(ready3), 32'b001);
        tick();
        checkOutput("n3_sel_wrap", 32'(osel3), 32'h0);
        checkOutput("n3_data_wrap", 32'(odata3), 32'hC0);
        #1 checkOutput("n3_ready_skip", 32'(ready3), 32'b100);
        tick();
        checkOutput("n3_sel_skip", 32'(osel3), 32'h2);
        valid3 = '0;

        validF = 4'b1010;
        repeat (4) begin
            #1 checkOutput("fixed_ready", 32'(readyF), 32'b0010);
            tick();
            checkOutput("fixed_sel", 32'(oselF), 32'h1);
            checkOutput("fixed_data", 32'(odataF), 32'h22);
        end
        validF = '0;

        valid1 = 1'b1;
        #1 checkOutput("n1_ready", 32'(ready1), 32'h1);
        tick();
        checkOutput("n1_valid", 32'(ovalid1), 32'h1);
        checkOutput("n1_data", 32'(odata1), 32'h5A);
        checkOutput("n1_sel", 32'(osel1), 32'h0);
        valid1 = 1'b0;
        tick();
        checkOutput("n1_drain", 32'(ovalid1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
